// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
// Shared types and constants for the multicycle MIPS controller:
//   statetype_t  - controller FSM states
//   aluop_t      - coarse ALU request from the FSM (ADD, SUB, FUNCT)
//   OP_*         - primary opcodes (IR[31:26])
//   FN_*         - R-type funct codes (IR[5:0])
//   ALUC_*       - ALU control codes driven to the datapath
// -----------------------------------------------------------------------------
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEX    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        JR      = 4'd12,
        ILLEGAL = 4'd13
    } statetype_t;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1100;

endpackage

// File: rtl/mips_mc_aludec.sv
// -----------------------------------------------------------------------------
// mips_mc_aludec
// Combinational ALU decoder.
//   aluop       in  2      coarse request from the FSM (aluop_t encoding)
//   funct       in  FW     R-type funct field
//   alucontrol  out ALUCW  ALU operation code
//   funct_legal out 1      funct is one of add/sub/and/or/slt/nor/jr
// -----------------------------------------------------------------------------
module mips_mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int FW    = 6,
    parameter int ALUCW = 4
) (
    input  logic [1:0]       aluop,
    input  logic [FW-1:0]    funct,
    output logic [ALUCW-1:0] alucontrol,
    output logic             funct_legal
);

    // ALU operation select from the FSM request and funct field
    always_comb begin
        alucontrol = ALUCW'(ALUC_ADD);
        case (aluop_t'(aluop))
            ADD: alucontrol = ALUCW'(ALUC_ADD);
            SUB: alucontrol = ALUCW'(ALUC_SUB);
            FUNCT: begin
                case (funct)
                    FW'(FN_ADD): alucontrol = ALUCW'(ALUC_ADD);
                    FW'(FN_SUB): alucontrol = ALUCW'(ALUC_SUB);
                    FW'(FN_AND): alucontrol = ALUCW'(ALUC_AND);
                    FW'(FN_OR):  alucontrol = ALUCW'(ALUC_OR);
                    FW'(FN_SLT): alucontrol = ALUCW'(ALUC_SLT);
                    FW'(FN_NOR): alucontrol = ALUCW'(ALUC_NOR);
                    default:     alucontrol = ALUCW'(ALUC_ADD);
                endcase
            end
            default: alucontrol = ALUCW'(ALUC_ADD);
        endcase
    end

    // Supported R-type funct codes (jr included; the FSM routes it separately)
    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            FW'(FN_ADD), FW'(FN_SUB), FW'(FN_AND), FW'(FN_OR),
            FW'(FN_SLT), FW'(FN_NOR), FW'(FN_JR): funct_legal = 1'b1;
            default:                              funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
// Multicycle MIPS control FSM (Moore). Sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
//   clk, reset        clock, asynchronous active-high reset
//   op, funct, zero   instruction fields and ALU zero flag
//   mem_ready         memory finished the current access this cycle
//   iord .. pcen      datapath selects/enables
//   alucontrol        ALU operation code
//   illegal           one-cycle pulse on an unsupported instruction
//   busy_wait         FSM is stalled waiting for mem_ready
// All outputs are held at 0 while reset is high.
// -----------------------------------------------------------------------------
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int FW     = 6,
    parameter int ALUCW  = 4,
    parameter bit MEM_HS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   op,
    input  logic [FW-1:0]    funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [ALUCW-1:0] alucontrol,
    output logic             illegal,
    output logic             busy_wait
);

    statetype_t       state_q, state_d;
    aluop_t           aluop_s;
    logic             rdy_s, funct_legal_s;
    logic [ALUCW-1:0] aluc_s;
    logic             iord_s, memread_s, memwrite_s, irwrite_s, regdst_s;
    logic             memtoreg_s, regwrite_s, alusrca_s, pcen_s, illegal_s, busy_s;
    logic [1:0]       alusrcb_s, pcsrc_s;

    // Without a handshake the memory is assumed to answer in one cycle
    assign rdy_s = MEM_HS ? mem_ready : 1'b1;

    mips_mc_aludec #(.FW(FW), .ALUCW(ALUCW)) u_aludec (
        .aluop       (aluop_s),
        .funct       (funct),
        .alucontrol  (aluc_s),
        .funct_legal (funct_legal_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d    = FETCH;
        aluop_s    = ADD;
        iord_s     = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        pcen_s     = 1'b0;
        illegal_s  = 1'b0;
        busy_s     = 1'b0;
        case (state_q)
            FETCH: begin
                memread_s = 1'b1;
                alusrcb_s = 2'b01;
                irwrite_s = rdy_s;
                pcen_s    = rdy_s;
                busy_s    = ~rdy_s;
                state_d   = rdy_s ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) begin
                    state_d = MEMADR;
                end else if (op == OPW'(OP_RTYPE)) begin
                    if (funct == FW'(FN_JR)) begin
                        state_d = JR;
                    end else if (funct_legal_s) begin
                        state_d = RTEX;
                    end else begin
                        state_d = ILLEGAL;
                    end
                end else if (op == OPW'(OP_BEQ) || op == OPW'(OP_BNE)) begin
                    state_d = BRANCH;
                end else if (op == OPW'(OP_ADDI)) begin
                    state_d = ADDIEX;
                end else if (op == OPW'(OP_J)) begin
                    state_d = JUMP;
                end else begin
                    state_d = ILLEGAL;
                end
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = (op == OPW'(OP_SW)) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread_s = 1'b1;
                iord_s    = 1'b1;
                busy_s    = ~rdy_s;
                state_d   = rdy_s ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                memwrite_s = 1'b1;
                iord_s     = 1'b1;
                busy_s     = ~rdy_s;
                state_d    = rdy_s ? FETCH : MEMWR;
            end
            RTEX: begin
                alusrca_s = 1'b1;
                aluop_s   = FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = SUB;
                pcsrc_s   = 2'b01;
                // bne inverts the sense of the zero flag
                pcen_s    = zero ^ (op == OPW'(OP_BNE));
                state_d   = FETCH;
            end
            ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc_s = 2'b10;
                pcen_s  = 1'b1;
                state_d = FETCH;
            end
            JR: begin
                pcsrc_s = 2'b11;
                pcen_s  = 1'b1;
                state_d = FETCH;
            end
            ILLEGAL: begin
                illegal_s = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset forces every output low, including the ALU code
    assign iord       = reset ? 1'b0 : iord_s;
    assign memread    = reset ? 1'b0 : memread_s;
    assign memwrite   = reset ? 1'b0 : memwrite_s;
    assign irwrite    = reset ? 1'b0 : irwrite_s;
    assign regdst     = reset ? 1'b0 : regdst_s;
    assign memtoreg   = reset ? 1'b0 : memtoreg_s;
    assign regwrite   = reset ? 1'b0 : regwrite_s;
    assign alusrca    = reset ? 1'b0 : alusrca_s;
    assign alusrcb    = reset ? 2'b00 : alusrcb_s;
    assign pcsrc      = reset ? 2'b00 : pcsrc_s;
    assign pcen       = reset ? 1'b0 : pcen_s;
    assign alucontrol = reset ? {ALUCW{1'b0}} : aluc_s;
    assign illegal    = reset ? 1'b0 : illegal_s;
    assign busy_wait  = reset ? 1'b0 : busy_s;

endmodule
